// File: rtl/led_bar_pkg.sv
// Shared types and constants for the LED bar-graph receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package led_bar_pkg;

    // Debounce FSM: SETTLE while waiting for a stable sample, LOCKED once evaluated.
    typedef enum logic {
        SETTLE = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int BAR_WIDTH  = 8;
    localparam int BAR_STABLE = 4;

    // Bits needed to represent a fill level in the range 0..width.
    function automatic int level_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/led_bar_decoder_thermo_check.sv
// Classifies an MSB-filled thermometer pattern and counts its leading ones.
// Latency: combinational, zero cycles.
// Backpressure: none (pure function of the input pattern).
//
// Ports:
//   pattern   in   WIDTH  bar pattern, bit WIDTH-1 is the first LED
//   is_therm  out  1      pattern is ones from the MSB followed only by zeros
//   level     out  LW     number of leading ones starting at the MSB
module thermo_check
    import led_bar_pkg::*;
#(
    parameter  int WIDTH = BAR_WIDTH,
    localparam int LW    = level_width(WIDTH)
) (
    input  logic [WIDTH-1:0] pattern,
    output logic             is_therm,
    output logic [LW-1:0]    level
);

    logic seen_zero;

    // Walk from the MSB down: ones before the first zero add to the level,
    // any one after a zero makes the pattern malformed.
    always_comb begin
        seen_zero = 1'b0;
        is_therm  = 1'b1;
        level     = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (pattern[i]) begin
                if (seen_zero) begin
                    is_therm = 1'b0;
                end else begin
                    level = level + LW'(1);
                end
            end else begin
                seen_zero = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_bar_decoder.sv
// Debounces an LED bar pattern, decodes its fill level, delivers new levels, tracks peak and errors.
// Latency: a pattern held STABLE_CYCLES+1 edges is evaluated on the last of them.
// Backpressure: level_valid holds until level_ready; a newer level overwrites a pending one.
//
// Ports:
//   clk          in   1      system clock
//   reset        in   1      asynchronous active-high reset
//   inled        in   WIDTH  bar pattern, bit WIDTH-1 = first LED lit
//   level_out    out  LW     most recently accepted level
//   level_valid  out  1      level_out not yet taken by the consumer
//   level_ready  in   1      consumer accepts level_out
//   peak_level   out  LW     highest accepted level since reset / peak_clr
//   peak_clr     in   1      pulse: peak_level restarts from the current accepted level
//   pattern_err  out  1      sticky flag: a stable malformed pattern was seen
//   err_pattern  out  WIDTH  last stable malformed pattern
//   err_clr      in   1      pulse: clear pattern_err
module led_bar_decoder
    import led_bar_pkg::*;
#(
    parameter  int WIDTH         = BAR_WIDTH,
    parameter  int STABLE_CYCLES = BAR_STABLE,
    localparam int LW            = level_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] inled,
    output logic [LW-1:0]    level_out,
    output logic             level_valid,
    input  logic             level_ready,
    output logic [LW-1:0]    peak_level,
    input  logic             peak_clr,
    output logic             pattern_err,
    output logic [WIDTH-1:0] err_pattern,
    input  logic             err_clr
);

    localparam int            CW  = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] STB = CW'(STABLE_CYCLES);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [LW-1:0]    acc_lvl_q, acc_lvl_d;
    logic [LW-1:0]    level_q, level_d;
    logic             valid_q, valid_d;
    logic [LW-1:0]    peak_q, peak_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] err_pat_q, err_pat_d;

    logic             is_therm;
    logic [LW-1:0]    s_level;
    logic             same;
    logic             evaluate;
    logic             accept;
    logic             malformed;

    thermo_check #(.WIDTH(WIDTH)) u_thermo_check (
        .pattern  (s_q),
        .is_therm (is_therm),
        .level    (s_level)
    );

    always_comb begin
        state_d   = state_q;
        s_d       = inled;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        acc_lvl_d = acc_lvl_q;
        level_d   = level_q;
        valid_d   = valid_q;
        peak_d    = peak_q;
        err_d     = err_q;
        err_pat_d = err_pat_q;
        evaluate  = 1'b0;

        same = (inled == s_q);

        // Stability counter: any change restarts it, otherwise it saturates.
        if (!same) begin
            cnt_d = '0;
        end else if (cnt_q != STB) begin
            cnt_d = cnt_q + CW'(1);
        end

        // Evaluate exactly once on the edge where the counter first reaches the
        // threshold; LOCKED blocks re-evaluation until the input moves again.
        case (state_q)
            SETTLE: begin
                if (cnt_d == STB) begin
                    state_d  = LOCKED;
                    evaluate = 1'b1;
                end
            end
            LOCKED: begin
                if (!same) begin
                    state_d = SETTLE;
                end
            end
            default: state_d = SETTLE;
        endcase

        // Only a level different from the last accepted one is delivered.
        accept    = evaluate &  is_therm & (s_q != acc_q);
        malformed = evaluate & ~is_therm;

        // Transfer first, then a same-edge acceptance re-arms valid.
        if (valid_q && level_ready) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            valid_d   = 1'b1;
            level_d   = s_level;
            acc_d     = s_q;
            acc_lvl_d = s_level;
        end

        // peak_clr restarts the peak from the accepted level, which is the new
        // one if an acceptance happens on the same edge.
        if (accept) begin
            if (peak_clr || (s_level > peak_q)) begin
                peak_d = s_level;
            end
        end else if (peak_clr) begin
            peak_d = acc_lvl_q;
        end

        // Set has priority over clear.
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (malformed) begin
            err_d     = 1'b1;
            err_pat_d = s_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= SETTLE;
            s_q       <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            acc_lvl_q <= '0;
            level_q   <= '0;
            valid_q   <= 1'b0;
            peak_q    <= '0;
            err_q     <= 1'b0;
            err_pat_q <= '0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            acc_lvl_q <= acc_lvl_d;
            level_q   <= level_d;
            valid_q   <= valid_d;
            peak_q    <= peak_d;
            err_q     <= err_d;
            err_pat_q <= err_pat_d;
        end
    end

    assign level_out   = level_q;
    assign level_valid = valid_q;
    assign peak_level  = peak_q;
    assign pattern_err = err_q;
    assign err_pattern = err_pat_q;

endmodule
